// File: rtl/sd_cmd_phy_pkg.sv
// Shared definitions for the SD host stack: CMD PHY state encodings, frame sizes,
// response-length codes and the CRC7 step function.
package sd_host_stack_defines;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_NCC,
    ST_TURN,
    ST_WAIT,
    ST_RX,
    ST_DONE
  } phy_state_t;

  localparam logic [6:0] CRC7_POLY           = 7'h09;
  localparam logic [7:0] CMD_FRAME_LEN       = 8'd48;
  localparam logic [7:0] SHORT_RSP_FRAME_LEN = 8'd48;
  localparam logic [7:0] LONG_RSP_FRAME_LEN  = 8'd136;
  localparam logic [7:0] TURNAROUND_BITS     = 8'd2;
  localparam logic [7:0] NCC_BITS            = 8'd8;

  localparam logic [7:0] RSP_LEN_NONE  = 8'd0;
  localparam logic [7:0] RSP_LEN_SHORT = 8'd40;
  localparam logic [7:0] RSP_LEN_LONG  = 8'd136;

  // CRC7 plus end bit that follow the payload of every frame
  localparam logic [7:0] FRAME_TRAILER_BITS = CMD_FRAME_LEN - RSP_LEN_SHORT;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    crc7_step = {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & CRC7_POLY);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first; clear has priority over enable.
module sd_crc7
  import sd_host_stack_defines::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= '0;
    else if (clr)
      crc <= '0;
    else if (en)
      crc <= crc7_step(crc, din);
  end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD line PHY: sends a 48-bit command frame, optionally receives a 48/136-bit response.
// Build option SD_CMD_PHY_RSP_CRC_EN adds the receive CRC7 check to o_crc_bad.
module sd_cmd_phy
  import sd_host_stack_defines::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bit_stb,
  input  logic         i_cmd_en,
  input  logic [39:0]  i_cmd,
  input  logic [7:0]   i_cmd_len,
  input  logic [7:0]   i_rsp_len,
  input  logic [15:0]  i_timeout,
  output logic         o_rsp_finished_en,
  output logic [135:0] o_rsp,
  output logic         o_crc_bad,
  output logic         o_timeout,
  output logic         o_sd_cmd_dir,
  output logic         o_sd_cmd,
  input  logic         i_sd_cmd
);

  phy_state_t     state;
  logic [7:0]     bit_cnt;
  logic [15:0]    wait_cnt;
  logic [39:0]    tx_sr;
  logic [135:0]   rx_sr;
  logic [7:0]     cmd_len_q;
  logic [7:0]     rsp_len_q;
  logic [15:0]    timeout_q;

  logic [6:0]     crc;
  logic           crc_clr;
  logic           crc_en;
  logic           crc_din;

  logic           rsp_long;
  logic [7:0]     rx_last;
  logic [7:0]     tx_last;
  logic [2:0]     crc_pos;
  logic [15:0]    wait_next;
  logic           start_seen;
  logic           rx_bad;

  assign rsp_long   = (rsp_len_q == RSP_LEN_LONG);
  assign rx_last    = (rsp_long ? LONG_RSP_FRAME_LEN : SHORT_RSP_FRAME_LEN) - 8'd1;
  assign tx_last    = cmd_len_q + FRAME_TRAILER_BITS - 8'd1;
  assign crc_pos    = 3'(bit_cnt - cmd_len_q);
  assign wait_next  = (&wait_cnt) ? wait_cnt : wait_cnt + 16'd1;
  assign start_seen = (state == ST_WAIT) && i_bit_stb && !i_sd_cmd;

`ifdef SD_CMD_PHY_RSP_CRC_EN
  logic [7:0] rx_pos;
  logic       rx_in_crc;

  // Long responses exclude their 8 header bits from the CRC; the start bit of a
  // short response is 0 and so contributes nothing after the clear.
  assign rx_pos    = rx_last - bit_cnt;
  assign rx_in_crc = (rx_pos >= FRAME_TRAILER_BITS) &&
                     (rx_pos < LONG_RSP_FRAME_LEN - FRAME_TRAILER_BITS);
  assign rx_bad    = (crc != rx_sr[6:0]) || !i_sd_cmd;
`else
  assign rx_bad    = !i_sd_cmd;
`endif

  always_comb begin
    crc_clr = (state == ST_IDLE) && i_cmd_en;
    crc_en  = (state == ST_TX) && i_cmd_en && i_bit_stb && (bit_cnt < cmd_len_q);
    crc_din = tx_sr[39];
`ifdef SD_CMD_PHY_RSP_CRC_EN
    if (start_seen)
      crc_clr = 1'b1;
    if ((state == ST_RX) && i_cmd_en && i_bit_stb && rx_in_crc) begin
      crc_en  = 1'b1;
      crc_din = i_sd_cmd;
    end
`endif
  end

  sd_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      bit_cnt           <= '0;
      wait_cnt          <= '0;
      tx_sr             <= '0;
      rx_sr             <= '0;
      cmd_len_q         <= '0;
      rsp_len_q         <= '0;
      timeout_q         <= '0;
      o_rsp             <= '0;
      o_rsp_finished_en <= 1'b0;
      o_crc_bad         <= 1'b0;
      o_timeout         <= 1'b0;
      o_sd_cmd_dir      <= 1'b0;
      o_sd_cmd          <= 1'b1;
    end else if (!i_cmd_en) begin
      state             <= ST_IDLE;
      o_rsp_finished_en <= 1'b0;
      o_sd_cmd_dir      <= 1'b0;
      o_sd_cmd          <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_sr     <= i_cmd;
          cmd_len_q <= i_cmd_len;
          rsp_len_q <= i_rsp_len;
          timeout_q <= i_timeout;
          rx_sr     <= '0;
          bit_cnt   <= '0;
          wait_cnt  <= '0;
          o_rsp     <= '0;
          o_crc_bad <= 1'b0;
          o_timeout <= 1'b0;
          state     <= ST_TX;
        end
        ST_TX: if (i_bit_stb) begin
          o_sd_cmd_dir <= 1'b1;
          if (bit_cnt < cmd_len_q) begin
            o_sd_cmd <= tx_sr[39];
            tx_sr    <= {tx_sr[38:0], 1'b0};
          end else if (bit_cnt < tx_last) begin
            o_sd_cmd <= crc[3'd6 - crc_pos];
          end else begin
            o_sd_cmd <= 1'b1;
          end
          if (bit_cnt == tx_last) begin
            bit_cnt <= '0;
            state   <= (rsp_len_q == RSP_LEN_NONE) ? ST_NCC : ST_TURN;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_NCC: if (i_bit_stb) begin
          o_sd_cmd <= 1'b1;
          if (bit_cnt == NCC_BITS - 8'd1) begin
            o_rsp_finished_en <= 1'b1;
            state             <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_TURN: if (i_bit_stb) begin
          o_sd_cmd_dir <= 1'b0;
          o_sd_cmd     <= 1'b1;
          if (bit_cnt == TURNAROUND_BITS - 8'd1) begin
            bit_cnt <= '0;
            state   <= ST_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_WAIT: if (i_bit_stb) begin
          // A start bit beats a timeout landing on the same strobe
          if (start_seen) begin
            rx_sr   <= {rx_sr[134:0], 1'b0};
            bit_cnt <= 8'd1;
            state   <= ST_RX;
          end else begin
            wait_cnt <= wait_next;
            if ((timeout_q != '0) && (wait_next == timeout_q)) begin
              o_timeout         <= 1'b1;
              o_rsp_finished_en <= 1'b1;
              state             <= ST_DONE;
            end
          end
        end
        ST_RX: if (i_bit_stb) begin
          rx_sr <= {rx_sr[134:0], i_sd_cmd};
          if (bit_cnt == rx_last) begin
            o_rsp             <= rsp_long ? {rx_sr[134:0], i_sd_cmd} : {96'd0, rx_sr[46:7]};
            o_crc_bad         <= rx_bad;
            o_rsp_finished_en <= 1'b1;
            state             <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_DONE: if (i_bit_stb) begin
          o_sd_cmd_dir <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: TX bits and transaction results are queued as
// expectations when a command is launched and compared as the DUT produces them.
module tb_sd_cmd_phy;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_bit_stb;
  logic         i_cmd_en;
  logic [39:0]  i_cmd;
  logic [7:0]   i_cmd_len;
  logic [7:0]   i_rsp_len;
  logic [15:0]  i_timeout;
  logic         o_rsp_finished_en;
  logic [135:0] o_rsp;
  logic         o_crc_bad;
  logic         o_timeout;
  logic         o_sd_cmd_dir;
  logic         o_sd_cmd;
  logic         i_sd_cmd;

  always #5 clk = ~clk;

  sd_cmd_phy dut (
    .clk               (clk),
    .rst               (rst),
    .i_bit_stb         (i_bit_stb),
    .i_cmd_en          (i_cmd_en),
    .i_cmd             (i_cmd),
    .i_cmd_len         (i_cmd_len),
    .i_rsp_len         (i_rsp_len),
    .i_timeout         (i_timeout),
    .o_rsp_finished_en (o_rsp_finished_en),
    .o_rsp             (o_rsp),
    .o_crc_bad         (o_crc_bad),
    .o_timeout         (o_timeout),
    .o_sd_cmd_dir      (o_sd_cmd_dir),
    .o_sd_cmd          (o_sd_cmd),
    .i_sd_cmd          (i_sd_cmd)
  );

`ifdef SD_CMD_PHY_RSP_CRC_EN
  localparam logic RX_CRC_CHECKED = 1'b1;
`else
  localparam logic RX_CRC_CHECKED = 1'b0;
`endif

  typedef struct packed {
    logic [135:0] rsp;
    logic         bad;
    logic         to;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   stb_div = 1;
  logic tx_q[$];
  logic line_q[$];
  res_t res_q[$];

  task automatic check_eq(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic bit_step(input logic line);
    repeat (stb_div - 1) begin
      @(posedge clk);
      #1;
    end
    i_sd_cmd  = line;
    i_bit_stb = 1'b1;
    @(posedge clk);
    #1;
    i_bit_stb = 1'b0;
  endtask

  task automatic xact(input string name, input logic [39:0] cmd, input logic [47:0] tx_frame,
                      input logic [7:0] rsp_len, input logic [15:0] tmo,
                      input logic [135:0] rsp_frame, input int rsp_bits, input int idle,
                      input res_t exp, input int exp_steps, input int abort_step,
                      input bit abort_rst);
    logic had_tx;
    logic exp_bit;
    logic line;
    int   steps;
    bit   done;
    res_t rs;

    for (int i = 47; i >= 0; i--) tx_q.push_back(tx_frame[i]);
    if (rsp_len == 8'd0) repeat (8) tx_q.push_back(1'b1);
    res_q.push_back(exp);
    repeat (48 + idle) line_q.push_back(1'b1);
    for (int i = rsp_bits - 1; i >= 0; i--) line_q.push_back(rsp_frame[i]);

    i_cmd     = cmd;
    i_cmd_len = 8'd40;
    i_rsp_len = rsp_len;
    i_timeout = tmo;
    i_cmd_en  = 1'b1;
    @(posedge clk);
    #1;

    steps = 0;
    done  = 1'b0;
    while (!done && steps < 400) begin
      had_tx = (tx_q.size() > 0);
      line   = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
      bit_step(line);
      steps++;
      check_eq({name, "_dir"}, o_sd_cmd_dir, had_tx);
      if (had_tx) begin
        exp_bit = tx_q.pop_front();
        check_eq({name, "_txbit"}, o_sd_cmd, exp_bit);
      end
      if (steps == abort_step) begin
        if (abort_rst) begin
          #2 rst = 1'b1;
          #1 check_eq({name, "_rst_dir"}, o_sd_cmd_dir, 1'b0);
          i_cmd_en = 1'b0;
          @(posedge clk);
          #1 rst = 1'b0;
          check_eq({name, "_rst_rsp"}, o_rsp, 136'd0);
        end else begin
          i_cmd_en = 1'b0;
          @(posedge clk);
          #1 check_eq({name, "_abort_dir"}, o_sd_cmd_dir, 1'b0);
          check_eq({name, "_abort_rsp"}, o_rsp, 136'd0);
        end
        check_eq({name, "_abort_line"}, o_sd_cmd, 1'b1);
        check_eq({name, "_abort_fin"}, o_rsp_finished_en, 1'b0);
        @(posedge clk);
        #1;
        tx_q.delete();
        line_q.delete();
        rs = res_q.pop_front();
        return;
      end
      done = o_rsp_finished_en;
    end

    check_eq({name, "_fin"}, o_rsp_finished_en, 1'b1);
    check_eq({name, "_steps"}, steps, exp_steps);
    check_eq({name, "_tx_left"}, tx_q.size(), 0);
    rs = res_q.pop_front();
    check_eq({name, "_rsp"}, o_rsp, rs.rsp);
    check_eq({name, "_crc_bad"}, o_crc_bad, rs.bad);
    check_eq({name, "_timeout"}, o_timeout, rs.to);

    repeat (3) bit_step(1'b1);
    check_eq({name, "_hold_fin"}, o_rsp_finished_en, 1'b1);
    check_eq({name, "_hold_rsp"}, o_rsp, rs.rsp);

    i_cmd_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq({name, "_drop_fin"}, o_rsp_finished_en, 1'b0);
    check_eq({name, "_drop_dir"}, o_sd_cmd_dir, 1'b0);
    check_eq({name, "_drop_rsp"}, o_rsp, rs.rsp);
    check_eq({name, "_drop_bad"}, o_crc_bad, rs.bad);
    line_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [135:0] long_frame;
    res_t         none;

    rst       = 1'b1;
    i_bit_stb = 1'b0;
    i_cmd_en  = 1'b0;
    i_cmd     = '0;
    i_cmd_len = 8'd40;
    i_rsp_len = '0;
    i_timeout = '0;
    i_sd_cmd  = 1'b1;
    none      = '{136'd0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dir", o_sd_cmd_dir, 1'b0);
    check_eq("rst_line", o_sd_cmd, 1'b1);
    check_eq("rst_rsp", o_rsp, 136'd0);
    check_eq("rst_fin", o_rsp_finished_en, 1'b0);
    check_eq("rst_flags", {o_crc_bad, o_timeout}, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    xact("cmd0", 40'h4000000000, 48'h400000000095, 8'd0, 16'd0, 136'd0, 0, 0,
         none, 56, 0, 1'b0);
    xact("cmd8", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd0, 136'h08000001AA13, 48, 5,
         '{136'h08000001AA, 1'b0, 1'b0}, 101, 0, 1'b0);
    xact("cmd8_crcerr", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd0, 136'h08000001AB13, 48, 5,
         '{136'h08000001AB, RX_CRC_CHECKED, 1'b0}, 101, 0, 1'b0);
    xact("cmd8_endbit", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd0, 136'h08000001AA12, 48, 5,
         '{136'h08000001AA, 1'b1, 1'b0}, 101, 0, 1'b0);
    xact("timeout", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd64, 136'd0, 0, 0,
         '{136'd0, 1'b0, 1'b1}, 114, 0, 1'b0);
    xact("start_at_tmo", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd3, 136'h08000001AA13, 48, 4,
         '{136'h08000001AA, 1'b0, 1'b0}, 100, 0, 1'b0);

    long_frame = '0;
    long_frame[135:128] = 8'h3F;
    for (int i = 8; i < 128; i++) long_frame[i] = 1'($urandom_range(0, 1));
    long_frame[7:1] = crc7_model(long_frame, 127, 8);
    long_frame[0]   = 1'b1;
    stb_div = 4;
    xact("long", 40'h4200000000, 48'h42000000004D, 8'd136, 16'd0, long_frame, 136, 3,
         '{long_frame, 1'b0, 1'b0}, 187, 0, 1'b0);
    stb_div = 1;

    xact("abort_tx", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd0, 136'h08000001AA13, 48, 5,
         none, 0, 20, 1'b0);
    xact("cmd0_after_abort", 40'h4000000000, 48'h400000000095, 8'd0, 16'd0, 136'd0, 0, 0,
         none, 56, 0, 1'b0);
    xact("rst_rx", 40'h48000001AA, 48'h48000001AA87, 8'd40, 16'd0, 136'h08000001AA13, 48, 5,
         none, 0, 80, 1'b1);
    xact("cmd0_after_rst", 40'h4000000000, 48'h400000000095, 8'd0, 16'd0, 136'd0, 0, 0,
         none, 56, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
